// File: rtl/music_player.sv
// Playback sequencer: streams samples 0..len-1 from the loader RAM to the speaker at a fixed rate.
// Optional MUSIC_PLAYER_VOLUME_EN adds a 4-bit vol input that scales each sample by vol/16.
module music_player #(
  parameter int CLK_FREQ    = 27000000,
  parameter int SAMPLE_RATE = 8000,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int RD_LAT      = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_done,
  input  logic [ADDR_W-1:0] music_len,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data_out,
`ifdef MUSIC_PLAYER_VOLUME_EN
  input  logic [3:0]        vol,
`endif
  output logic [DATA_W-1:0] speaker_data,
  output logic              speaker_valid,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for an accepted start, speaker silent
  // PRIME | first read of sample 0 in flight
  // PLAY  | emitting one sample per tick, prefetching the next
  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  localparam int DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] idx, len_q, nxt;
  logic [DATA_W-1:0] sample_buf, scaled;
  logic [2:0]        lat_cnt;
  logic              pending;
  logic              abort, start_ok, sample_tick, last, finish, capture;

  assign busy        = (state != IDLE);
  assign abort       = stop | (busy & ~init_done);
  assign start_ok    = (state == IDLE) & start & init_done & (music_len != '0) & ~stop;
  assign sample_tick = (state == PLAY) & (cnt == CNT_MAX);
  assign last        = (idx == len_q - 1'b1);
  assign finish      = sample_tick & last & ~loop_en;
  assign capture     = pending & (lat_cnt == '0);
  assign nxt         = last ? '0 : idx + 1'b1;

`ifdef MUSIC_PLAYER_VOLUME_EN
  logic signed [DATA_W+4:0] prod;
  logic unused_prod;
  assign prod        = $signed(sample_buf) * $signed({1'b0, vol});
  assign scaled      = prod[DATA_W+3:4];
  assign unused_prod = ^{prod[DATA_W+4], prod[3:0]};
`else
  assign scaled = sample_buf;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = PRIME;
      PRIME:   if (capture)  state_n = PLAY;
      PLAY:    if (finish)   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt           <= '0;
      idx           <= '0;
      len_q         <= '0;
      sample_buf    <= '0;
      lat_cnt       <= '0;
      pending       <= 1'b0;
      ram_rd_en     <= 1'b0;
      ram_addr      <= '0;
      speaker_data  <= '0;
      speaker_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      ram_rd_en     <= 1'b0;
      speaker_valid <= 1'b0;
      done          <= 1'b0;
      if (state == IDLE || abort) begin
        // Abort drops any read still in flight along with the current sample.
        cnt          <= '0;
        pending      <= 1'b0;
        speaker_data <= '0;
        if (start_ok) begin
          len_q     <= music_len;
          idx       <= '0;
          ram_rd_en <= 1'b1;
          ram_addr  <= '0;
          lat_cnt   <= LAT_LOAD;
          pending   <= 1'b1;
        end
      end else begin
        cnt <= sample_tick ? '0 : cnt + 1'b1;
        if (pending) begin
          if (capture) begin
            sample_buf <= ram_data_out;
            pending    <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        if (sample_tick) begin
          speaker_data  <= scaled;
          speaker_valid <= 1'b1;
          if (finish) begin
            done <= 1'b1;
          end else begin
            ram_rd_en <= 1'b1;
            ram_addr  <= nxt;
            idx       <= nxt;
            lat_cnt   <= LAT_LOAD;
            pending   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with DIV=10, RD_LAT=1 and RAM[i]=0x0100+i.
// Cycle c means c rising edges after the edge that sampled start, observed 1ns after that edge.
module tb_music_player;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic [11:0] music_len = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        ram_rd_en;
  logic [11:0] ram_addr;
  logic [15:0] ram_data_out = '0;
  logic [15:0] speaker_data;
  logic        speaker_valid;
  logic        busy;
  logic        done;
  logic [15:0] ram0 = 16'h0100;
`ifdef MUSIC_PLAYER_VOLUME_EN
  logic [3:0]  vol = 4'd15;
`endif

  int checks = 0;
  int errors = 0;

  music_player #(
    .CLK_FREQ(1000), .SAMPLE_RATE(100), .ADDR_W(12), .DATA_W(16), .RD_LAT(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .music_len(music_len), .start(start), .stop(stop), .loop_en(loop_en),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_data_out(ram_data_out),
`ifdef MUSIC_PLAYER_VOLUME_EN
    .vol(vol),
`endif
    .speaker_data(speaker_data), .speaker_valid(speaker_valid),
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk)
    if (ram_rd_en) ram_data_out <= (ram_addr == 12'd0) ? ram0 : 16'h0100 + {4'b0, ram_addr};

  function automatic logic [15:0] exp_out(input int i);
    logic [15:0] raw;
    raw = 16'h0100 + 16'(i);
`ifdef MUSIC_PLAYER_VOLUME_EN
    return 16'((32'(raw) * 32'(vol)) >> 4);
`else
    return raw;
`endif
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({speaker_data, speaker_valid, busy, done, ram_rd_en, ram_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h valid=%b busy=%b done=%b rd=%b addr=%h exp all 0",
               speaker_data, speaker_valid, busy, done, ram_rd_en, ram_addr);
    end
    #4 sys_rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_one_shot();
    logic exp_v;
    init_done = 1'b1; music_len = 12'd4; loop_en = 1'b0;
    do_start();
    checks++;
    if (busy !== 1'b1 || ram_rd_en !== 1'b1 || ram_addr !== 12'd0) begin
      errors++;
      $display("FAIL one_shot_prime got busy=%b rd=%b addr=%h exp 1 1 000", busy, ram_rd_en, ram_addr);
    end
    for (int c = 1; c <= 41; c++) begin
      step();
      exp_v = (c % 10 == 0);
      checks++;
      if (speaker_valid !== exp_v) begin
        errors++;
        $display("FAIL one_shot_valid c=%0d got=%b exp=%b", c, speaker_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (speaker_data !== exp_out(c / 10 - 1)) begin
          errors++;
          $display("FAIL one_shot_data c=%0d got=%h exp=%h", c, speaker_data, exp_out(c / 10 - 1));
        end
      end
      checks++;
      if (done !== (c == 40)) begin
        errors++;
        $display("FAIL one_shot_done c=%0d got=%b exp=%b", c, done, (c == 40));
      end
    end
    checks++;
    if (busy !== 1'b0 || speaker_data !== 16'h0) begin
      errors++;
      $display("FAIL one_shot_end got busy=%b data=%h exp 0 0000", busy, speaker_data);
    end
  endtask

  task automatic test_loop();
    logic exp_v;
    music_len = 12'd3; loop_en = 1'b1;
    do_start();
    for (int c = 1; c <= 61; c++) begin
      step();
      exp_v = (c % 10 == 0);
      checks++;
      if (speaker_valid !== exp_v) begin
        errors++;
        $display("FAIL loop_valid c=%0d got=%b exp=%b", c, speaker_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (speaker_data !== exp_out((c / 10 - 1) % 3)) begin
          errors++;
          $display("FAIL loop_data c=%0d got=%h exp=%h", c, speaker_data, exp_out((c / 10 - 1) % 3));
        end
      end
      checks++;
      if (done !== (c == 60)) begin
        errors++;
        $display("FAIL loop_done c=%0d got=%b exp=%b", c, done, (c == 60));
      end
      if (c == 55) loop_en = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_end got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_stop();
    music_len = 12'd4; loop_en = 1'b0;
    do_start();
    repeat (20) step();
    checks++;
    if (speaker_valid !== 1'b1 || speaker_data !== exp_out(1)) begin
      errors++;
      $display("FAIL stop_pre got valid=%b data=%h exp 1 %h", speaker_valid, speaker_data, exp_out(1));
    end
    repeat (5) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || speaker_data !== 16'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stop_abort got busy=%b data=%h done=%b exp 0 0000 0", busy, speaker_data, done);
    end
    for (int c = 27; c <= 56; c++) begin
      step();
      checks++;
      if (speaker_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL stop_quiet c=%0d got valid=%b done=%b busy=%b exp 0 0 0", c, speaker_valid, done, busy);
      end
    end
  endtask

  task automatic test_ignored_start();
    init_done = 1'b0; music_len = 12'd4;
    do_start();
    checks++;
    if (busy !== 1'b0 || ram_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL ign_init got busy=%b rd=%b exp 0 0", busy, ram_rd_en);
    end
    init_done = 1'b1; music_len = 12'd0;
    do_start();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_len0 got busy=%b exp 0", busy);
    end
    music_len = 12'd4;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_stop got busy=%b exp 0", busy);
    end
    repeat (10) step();
    checks++;
    if (busy !== 1'b0 || speaker_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_later got busy=%b valid=%b exp 0 0", busy, speaker_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    music_len = 12'd4; loop_en = 1'b0;
    do_start();
    for (int c = 1; c <= 41; c++) begin
      step();
      exp_v = (c % 10 == 0);
      checks++;
      if (speaker_valid !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, speaker_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (speaker_data !== exp_out(c / 10 - 1)) begin
          errors++;
          $display("FAIL b2b_data c=%0d got=%h exp=%h", c, speaker_data, exp_out(c / 10 - 1));
        end
      end
      checks++;
      if (done !== (c == 40)) begin
        errors++;
        $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, (c == 40));
      end
      if (c == 15) begin
        start = 1'b1; music_len = 12'd2;
      end else if (c == 16) begin
        start = 1'b0;
      end
    end
    music_len = 12'd4;
  endtask

  task automatic test_reset_mid_play();
    music_len = 12'd4;
    do_start();
    repeat (17) step();
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({speaker_data, speaker_valid, busy, done, ram_rd_en, ram_addr} !== '0) begin
      errors++;
      $display("FAIL rst_mid got data=%h valid=%b busy=%b done=%b rd=%b addr=%h exp all 0",
               speaker_data, speaker_valid, busy, done, ram_rd_en, ram_addr);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    do_start();
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if (speaker_valid !== (c == 10)) begin
        errors++;
        $display("FAIL rst_restart_valid c=%0d got=%b exp=%b", c, speaker_valid, (c == 10));
      end
    end
    checks++;
    if (speaker_data !== exp_out(0)) begin
      errors++;
      $display("FAIL rst_restart_data got=%h exp=%h", speaker_data, exp_out(0));
    end
    music_len = 12'd0;
    repeat (40) step();
  endtask

`ifdef MUSIC_PLAYER_VOLUME_EN
  task automatic test_volume();
    ram0 = 16'h8000; vol = 4'd8; music_len = 12'd1; loop_en = 1'b0;
    do_start();
    repeat (10) step();
    checks++;
    if (speaker_valid !== 1'b1 || speaker_data !== 16'hC000 || done !== 1'b1) begin
      errors++;
      $display("FAIL vol8 got valid=%b data=%h done=%b exp 1 c000 1", speaker_valid, speaker_data, done);
    end
    step();
    vol = 4'd0;
    do_start();
    repeat (10) step();
    checks++;
    if (speaker_valid !== 1'b1 || speaker_data !== 16'h0000) begin
      errors++;
      $display("FAIL vol0 got valid=%b data=%h exp 1 0000", speaker_valid, speaker_data);
    end
    step();
    ram0 = 16'h0100; vol = 4'd15;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_one_shot();
    repeat (3) step();
    test_loop();
    repeat (3) step();
    test_stop();
    test_ignored_start();
    test_back_to_back();
    repeat (3) step();
    test_reset_mid_play();
`ifdef MUSIC_PLAYER_VOLUME_EN
    test_volume();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
